// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared memory-side constants and arbiter FSM state encodings
package mips_mem_pkg;

    localparam int DEF_AW = 32;
    localparam int DEF_DW = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_ACK     = 2'd3
    } arb_state_t;

endpackage

// File: rtl/data_ram_arbiter_if.sv
// rtl/data_ram_arbiter_if.sv - requester ports and RAM strobes of the data RAM arbiter
interface data_ram_arbiter_if #(
    parameter int AW = mips_mem_pkg::DEF_AW,
    parameter int DW = mips_mem_pkg::DEF_DW
);
    logic          req0;
    logic          req1;
    logic          we0;
    logic          we1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic          ack0;
    logic          ack1;
    logic [DW-1:0] rdata0;
    logic [DW-1:0] rdata1;
    logic          busy;
    logic          m_read;
    logic          m_write;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_din;
    logic [DW-1:0] m_dout;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, m_dout,
        output ack0, ack1, rdata0, rdata1, busy, m_read, m_write, m_addr, m_din
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, m_dout,
        input  ack0, ack1, rdata0, rdata1, busy, m_read, m_write, m_addr, m_din
    );

endinterface

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - combinational two-way request picker; DATA_ARB_FIXED_PRIO_EN selects fixed port-0 priority
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic grant,
    output logic valid
);

    assign valid = req0 | req1;

`ifdef DATA_ARB_FIXED_PRIO_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
    assign grant = ~req0;
`else
    // On a tie the port that did not win last time goes next.
    assign grant = (req0 & req1) ? ~last_grant : ~req0;
`endif

endmodule

// File: rtl/data_ram_arbiter.sv
// rtl/data_ram_arbiter.sv - two-port arbiter driving a single-port data RAM with registered read
module data_ram_arbiter
    import mips_mem_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
) (
    input  logic               clk,
    input  logic               rst,
    data_ram_arbiter_if.slave  bus
);

    arb_state_t    state;
    arb_state_t    state_nx;
    logic          pick_grant;
    logic          pick_valid;
    logic          grant_q;
    logic          we_q;
    logic          last_grant;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] din_q;
    logic [DW-1:0] rdata0_q;
    logic [DW-1:0] rdata1_q;

    rr_pick2 u_pick (
        .req0       (bus.req0),
        .req1       (bus.req1),
        .last_grant (last_grant),
        .grant      (pick_grant),
        .valid      (pick_valid)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        bus.m_read  = 1'b0;
        bus.m_write = 1'b0;
        bus.ack0    = 1'b0;
        bus.ack1    = 1'b0;
        bus.busy    = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_nx = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                bus.m_read  = ~we_q;
                bus.m_write = we_q;
                state_nx    = we_q ? ST_ACK : ST_CAPTURE;
            end
            ST_CAPTURE: begin
                state_nx = ST_ACK;
            end
            ST_ACK: begin
                bus.ack0 = ~grant_q;
                bus.ack1 = grant_q;
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Request fields are copied at grant so later changes by the requester are ignored.
    always_ff @(posedge clk) begin
        if (!rst) begin
            grant_q    <= 1'b0;
            we_q       <= 1'b0;
            last_grant <= 1'b1;
            addr_q     <= '0;
            din_q      <= '0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            if (state == ST_IDLE && pick_valid) begin
                grant_q    <= pick_grant;
                last_grant <= pick_grant;
                we_q       <= pick_grant ? bus.we1    : bus.we0;
                addr_q     <= pick_grant ? bus.addr1  : bus.addr0;
                din_q      <= pick_grant ? bus.wdata1 : bus.wdata0;
            end
            if (state == ST_CAPTURE) begin
                if (grant_q) begin
                    rdata1_q <= bus.m_dout;
                end else begin
                    rdata0_q <= bus.m_dout;
                end
            end
        end
    end

    assign bus.m_addr = addr_q;
    assign bus.m_din  = din_q;
    assign bus.rdata0 = rdata0_q;
    assign bus.rdata1 = rdata1_q;

endmodule

// File: tb/tb_data_ram_arbiter.sv
// tb/tb_data_ram_arbiter.sv - self-checking bench for data_ram_arbiter with a 1024x32 registered-read RAM model
module tb_data_ram_arbiter;

`ifdef DATA_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    data_ram_arbiter_if #(.AW(32), .DW(32)) bus ();

    data_ram_arbiter #(.AW(32), .DW(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] ram [1024];

    always @(posedge clk) begin
        if (bus.m_write) ram[bus.m_addr[9:0]] <= bus.m_din;
        if (bus.m_read)  bus.m_dout <= ram[bus.m_addr[9:0]];
    end

    logic [31:0] ref_mem [1024];
    logic [31:0] ref_rdata [2];
    int          ref_last;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ref_last     = 1;
        ref_rdata[0] = '0;
        ref_rdata[1] = '0;
    endtask

    function automatic int tie_winner();
        if (FIXED) return 0;
        return (ref_last == 0) ? 1 : 0;
    endfunction

    // Called at a negedge with the FSM idle (or mid-flight for exp_lat shortening); waits for the ack.
    task automatic serve(input int port, input int exp_lat, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
        int k;
        bit got;
        k   = 0;
        got = 1'b0;
        while (!got && k < 12) begin
            @(posedge clk);
            @(negedge clk);
            k++;
            if (bus.ack0 || bus.ack1) got = 1'b1;
        end
        chk($sformatf("ack_seen_p%0d", port), 32'(got), 32'd1);
        chk($sformatf("latency_p%0d", port), 32'(k), 32'(exp_lat));
        chk($sformatf("ack_port_p%0d", port), {30'd0, bus.ack1, bus.ack0}, (port == 1) ? 32'd2 : 32'd1);
        ref_last = port;
        if (w) ref_mem[a[9:0]] = d;
        else   ref_rdata[port] = ref_mem[a[9:0]];
        chk("rdata0", bus.rdata0, ref_rdata[0]);
        chk("rdata1", bus.rdata1, ref_rdata[1]);
        if (port == 0) bus.req0 = 1'b0;
        else           bus.req1 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("idle_after_ack", 32'(bus.busy), 32'd0);
    endtask

    task automatic run_round(input logic q0, input logic q1, input logic w0, input logic w1,
                             input logic [31:0] a0, input logic [31:0] a1,
                             input logic [31:0] d0, input logic [31:0] d1);
        int first;
        bus.req0 = q0; bus.we0 = w0; bus.addr0 = a0; bus.wdata0 = d0;
        bus.req1 = q1; bus.we1 = w1; bus.addr1 = a1; bus.wdata1 = d1;
        first = (q0 && q1) ? tie_winner() : (q0 ? 0 : 1);
        if (first == 0) serve(0, w0 ? 2 : 3, w0, a0, d0);
        else            serve(1, w1 ? 2 : 3, w1, a1, d1);
        if (q0 && q1) begin
            if (first == 0) serve(1, w1 ? 2 : 3, w1, a1, d1);
            else            serve(0, w0 ? 2 : 3, w0, a0, d0);
        end
    endtask

    initial begin
        int acks;
        int win;
        logic r0, r1;
        for (int i = 0; i < 1024; i++) begin
            ram[i]     = '0;
            ref_mem[i] = '0;
        end
        model_reset();
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'h10; bus.wdata0 = '0;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0;     bus.wdata1 = '0;

        // Reset held with a pending request
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_ack0", 32'(bus.ack0), 32'd0);
            chk("rst_strobes", {30'd0, bus.m_read, bus.m_write}, 32'd0);
            chk("rst_busy", 32'(bus.busy), 32'd0);
            chk("rst_rdata0", bus.rdata0, 32'd0);
            chk("rst_rdata1", bus.rdata1, 32'd0);
        end
        chk("rst_m_addr", bus.m_addr, 32'd0);
        bus.req0 = 1'b0;
        rst = 1'b1;
        @(negedge clk);

        // Write then read on port 0
        run_round(1, 0, 1, 0, 32'h10, 32'h0, 32'hDEADBEEF, 32'h0);
        run_round(1, 0, 0, 0, 32'h10, 32'h0, 32'h0, 32'h0);
        chk("wr_rd_rdata0", bus.rdata0, 32'hDEADBEEF);

        // Port isolation
        run_round(0, 1, 0, 1, 32'h0, 32'h20, 32'h0, 32'h1234);
        run_round(1, 0, 0, 0, 32'h20, 32'h0, 32'h0, 32'h0);
        chk("iso_rdata0", bus.rdata0, 32'h1234);

        // Continuous tie of reads from a fresh reset
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'h10;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 32'h20;
        acks = 0;
        for (int c = 1; c <= 32; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.ack0 || bus.ack1) begin
                win = tie_winner();
                acks++;
                chk("tie_ack_cycle", 32'(c % 4), 32'd3);
                chk("tie_ack_port", {30'd0, bus.ack1, bus.ack0}, (win == 1) ? 32'd2 : 32'd1);
                ref_last = win;
                ref_rdata[win] = ref_mem[(win == 1) ? 10'h20 : 10'h10];
                chk("tie_rdata0", bus.rdata0, ref_rdata[0]);
                chk("tie_rdata1", bus.rdata1, ref_rdata[1]);
            end
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        chk("tie_ack_count", 32'(acks), 32'd8);
        @(negedge clk);

        // Reset during ISSUE of a write
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 32'h5; bus.wdata0 = 32'hA5;
        @(posedge clk);
        @(negedge clk);
        chk("abort_m_write", 32'(bus.m_write), 32'd1);
        rst = 1'b0;
        bus.req0 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_ack0", 32'(bus.ack0), 32'd0);
        rst = 1'b1;
        ref_mem[5] = 32'hA5;
        model_reset();
        @(negedge clk);
        run_round(1, 0, 0, 0, 32'h5, 32'h0, 32'h0, 32'h0);
        chk("abort_read", bus.rdata0, 32'hA5);

        // Address changed after sampling
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'h10;
        @(posedge clk);
        @(negedge clk);
        bus.addr0 = 32'h30;
        chk("stab_m_addr", bus.m_addr, 32'h10);
        chk("stab_m_read", 32'(bus.m_read), 32'd1);
        serve(0, 2, 1'b0, 32'h10, 32'h0);
        chk("stab_rdata0", bus.rdata0, 32'hDEADBEEF);

        // Randomized rounds against the reference model
        for (int n = 0; n < 40; n++) begin
            r0 = 1'($urandom);
            r1 = 1'($urandom);
            if (!r0 && !r1) r0 = 1'b1;
            run_round(r0, r1, 1'($urandom), 1'($urandom),
                      ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 31)),
                      ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 31)),
                      $urandom, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
